// File: rtl/fp16_fixed_accumulator_pkg.sv
// Shared definitions for the FP16 MAC accumulate stage.
//   FRAC_W          fraction bits carried by the fixed-point accumulator
//   SIGN_B..MANT_LO FP16 field positions {sign, exp[4:0], mant[9:0]}, bias 15
//   EXP_MAX         all-ones exponent (Inf/NaN encodings)
//   acc_state_e     accumulator control FSM encoding
package fp16_fixed_accumulator_pkg;

    localparam int FRAC_W  = 24;
    localparam int SIGN_B  = 15;
    localparam int EXP_HI  = 14;
    localparam int EXP_LO  = 10;
    localparam int MANT_HI = 9;
    localparam int MANT_LO = 0;
    localparam int EXP_W   = EXP_HI - EXP_LO + 1;
    localparam int MANT_W  = MANT_HI - MANT_LO + 1;
    localparam int EXP_MAX = 31;

    typedef enum logic [1:0] {
        ST_ACCUM = 2'd0,
        ST_FLUSH = 2'd1,
        ST_HOLD  = 2'd2
    } acc_state_e;

endpackage

// File: rtl/fp16_fixed_accumulator_if.sv
// Handshake bundle between the FP16 multiplier, the accumulator and the
// result consumer.
//   in_valid/in_ready  product handshake; in_data FP16 product,
//                      in_ovf/in_unf multiplier flags, in_last ends a vector
//   out_valid/out_ready result handshake; out_acc signed sum (FRAC_W fraction
//                      bits), out_count elements in vector, out_err sticky error
// Modports: slave = accumulator side, master = producer/consumer side.
interface fp16_fixed_accumulator_if #(
    parameter int ACC_W = 48,
    parameter int CNT_W = 8
) ();
    logic             in_valid;
    logic             in_ready;
    logic [15:0]      in_data;
    logic             in_ovf;
    logic             in_unf;
    logic             in_last;
    logic             out_valid;
    logic             out_ready;
    logic [ACC_W-1:0] out_acc;
    logic [CNT_W-1:0] out_count;
    logic             out_err;

    modport slave (
        input  in_valid, in_data, in_ovf, in_unf, in_last, out_ready,
        output in_ready, out_valid, out_acc, out_count, out_err
    );

    modport master (
        output in_valid, in_data, in_ovf, in_unf, in_last, out_ready,
        input  in_ready, out_valid, out_acc, out_count, out_err
    );
endinterface

// File: rtl/fp16_fixed_accumulator_fp16_to_fixed.sv
// fp16_to_fixed: combinational FP16 -> signed fixed point (FRAC_W fraction bits).
//   in_data      FP16 {sign, exp, mant}
//   value        signed ACC_W result; zero/denormal and Inf/NaN give 0
//   special_err  exponent all ones (Inf/NaN)
// ACC_W must be at least 41 to hold the largest finite magnitude plus sign.
module fp16_to_fixed
    import fp16_fixed_accumulator_pkg::*;
#(
    parameter int ACC_W = 48
) (
    input  logic [15:0]             in_data,
    output logic signed [ACC_W-1:0] value,
    output logic                    special_err
);

    logic [EXP_W-1:0]  exp_f;
    logic [MANT_W-1:0] mant;
    logic [ACC_W-1:0]  mag;

    assign exp_f = in_data[EXP_HI:EXP_LO];
    assign mant  = in_data[MANT_HI:MANT_LO];

    // {1,mant} has 10 fraction bits; shifting by (e-1) lands the binary point
    // at FRAC_W=24 for bias 15, so every finite normal converts exactly.
    always_comb begin
        mag         = '0;
        special_err = 1'b0;
        if (exp_f == EXP_W'(EXP_MAX)) begin
            special_err = 1'b1;
        end else if (exp_f != '0) begin
            mag = {{(ACC_W-MANT_W-1){1'b0}}, 1'b1, mant} << (exp_f - EXP_W'(1));
        end
        value = in_data[SIGN_B] ? -$signed(mag) : $signed(mag);
    end

endmodule

// File: rtl/fp16_fixed_accumulator.sv
// fp16_fixed_accumulator: accumulate stage closing the FP16 MAC. Converts each
// product to fixed point, sums a vector terminated by in_last and presents one
// result per vector on a valid/ready output.
//   clk   rising-edge clock
//   rst   synchronous active-high reset
//   bus   fp16_fixed_accumulator_if.slave (product input + result output)
// Build option: define MAC_ACC_SAT_EN to saturate the accumulator on signed
// overflow (and flag err); otherwise the sum wraps silently.
//
// state | meaning
// ACCUM | accepting products, S1 term added into acc each cycle
// FLUSH | input stalled, last term added, result registered, acc cleared
// HOLD  | result valid, waiting for out_ready; input stalled
module fp16_fixed_accumulator
    import fp16_fixed_accumulator_pkg::*;
#(
    parameter int ACC_W = 48,
    parameter int CNT_W = 8
) (
    input  logic                          clk,
    input  logic                          rst,
    fp16_fixed_accumulator_if.slave       bus
);

    localparam logic signed [ACC_W-1:0] ACC_MAX = {1'b0, {(ACC_W-1){1'b1}}};
    localparam logic signed [ACC_W-1:0] ACC_MIN = {1'b1, {(ACC_W-1){1'b0}}};

    acc_state_e state, state_nxt;
    logic       in_ready_w, out_valid_w, hs;

    logic signed [ACC_W-1:0] conv_val;
    logic                    conv_special;

    logic                    s1_vld, s1_last, s1_err;
    logic signed [ACC_W-1:0] s1_val;

    logic signed [ACC_W-1:0] acc, sum_raw, sum;
    logic [CNT_W-1:0]        count, cnt_inc;
    logic                    err, sat_err;

    logic signed [ACC_W-1:0] out_acc_q;
    logic [CNT_W-1:0]        out_count_q;
    logic                    out_err_q;

    fp16_to_fixed #(.ACC_W(ACC_W)) u_conv (
        .in_data     (bus.in_data),
        .value       (conv_val),
        .special_err (conv_special)
    );

    always_ff @(posedge clk) begin
        if (rst) state <= ST_ACCUM;
        else     state <= state_nxt;
    end

    always_comb begin
        state_nxt   = state;
        in_ready_w  = 1'b0;
        out_valid_w = 1'b0;
        case (state)
            ST_ACCUM: begin
                in_ready_w = ~rst;
                if (bus.in_valid && bus.in_last) state_nxt = ST_FLUSH;
            end
            ST_FLUSH: state_nxt = ST_HOLD;
            ST_HOLD: begin
                out_valid_w = ~rst;
                if (bus.out_ready) state_nxt = ST_ACCUM;
            end
            default: state_nxt = ST_ACCUM;
        endcase
    end

    assign hs = bus.in_valid & in_ready_w;

    assign sum_raw = acc + s1_val;
    assign cnt_inc = (count == '1) ? count : count + CNT_W'(1);

`ifdef MAC_ACC_SAT_EN
    logic sum_ovf;
    // Overflow only when both operands share a sign and the result flips it.
    assign sum_ovf = (acc[ACC_W-1] == s1_val[ACC_W-1]) && (sum_raw[ACC_W-1] != acc[ACC_W-1]);
    assign sum     = sum_ovf ? (acc[ACC_W-1] ? ACC_MIN : ACC_MAX) : sum_raw;
    assign sat_err = sum_ovf;
`else
    assign sum     = sum_raw;
    assign sat_err = 1'b0;
`endif

    always_ff @(posedge clk) begin
        if (rst) begin
            s1_vld      <= 1'b0;
            s1_last     <= 1'b0;
            s1_err      <= 1'b0;
            s1_val      <= '0;
            acc         <= '0;
            count       <= '0;
            err         <= 1'b0;
            out_acc_q   <= '0;
            out_count_q <= '0;
            out_err_q   <= 1'b0;
        end else begin
            s1_vld <= hs;
            if (hs) begin
                s1_val  <= conv_val;
                s1_last <= bus.in_last;
                s1_err  <= conv_special | bus.in_ovf | bus.in_unf;
            end
            if (s1_vld) begin
                if (s1_last) begin
                    // The vector's final term goes straight to the result
                    // registers so the next vector starts from zero.
                    out_acc_q   <= sum;
                    out_count_q <= cnt_inc;
                    out_err_q   <= err | s1_err | sat_err;
                    acc         <= '0;
                    count       <= '0;
                    err         <= 1'b0;
                end else begin
                    acc   <= sum;
                    count <= cnt_inc;
                    err   <= err | s1_err | sat_err;
                end
            end
        end
    end

    assign bus.in_ready  = in_ready_w;
    assign bus.out_valid = out_valid_w;
    assign bus.out_acc   = out_acc_q;
    assign bus.out_count = out_count_q;
    assign bus.out_err   = out_err_q;

    // Keep the ACC_W >= 41 requirement visible alongside the limits above.
    localparam int ACC_W_MIN = 41;
    if (ACC_W < ACC_W_MIN) begin : g_acc_w_too_small
        $error("fp16_fixed_accumulator: ACC_W must be >= 41");
    end

endmodule

// File: tb/tb_fp16_fixed_accumulator.sv
module tb_fp16_fixed_accumulator;

    localparam int ACC_W   = 48;
    localparam int ACC_W_S = 41;
    localparam int CNT_W   = 8;

    logic clk = 1'b0;
    logic rst = 1'b1;

    int n_vec = 0;
    int n_bad = 0;

    logic [15:0] q_data[$];
    bit          q_flag[$];

    fp16_fixed_accumulator_if #(.ACC_W(ACC_W),   .CNT_W(CNT_W)) bus   ();
    fp16_fixed_accumulator_if #(.ACC_W(ACC_W_S), .CNT_W(CNT_W)) bus_s ();

    fp16_fixed_accumulator #(.ACC_W(ACC_W), .CNT_W(CNT_W)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    fp16_fixed_accumulator #(.ACC_W(ACC_W_S), .CNT_W(CNT_W)) dut_s (
        .clk (clk),
        .rst (rst),
        .bus (bus_s)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_vec++;
        assert (obs === exp)
        else begin
            n_bad++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    // Real value of an FP16 number scaled by 2^24.
    function automatic longint fp_ref(input logic [15:0] d);
        int     e;
        real    r;
        longint v;
        e = int'(d[14:10]);
        if (e == 0 || e == 31) return 0;
        r = (1024.0 + real'(int'(d[9:0]))) * 16384.0;
        if (e > 15) for (int k = 0; k < e - 15; k++) r = r * 2.0;
        else        for (int k = 0; k < 15 - e; k++) r = r / 2.0;
        v = longint'(r);
        return d[15] ? -v : v;
    endfunction

    task automatic model(input int accw, output longint acc, output int cnt, output bit err);
        longint      mx, mn, s, v;
        logic [15:0] d;
        mx  = (longint'(1) <<< (accw - 1)) - 1;
        mn  = -mx - 1;
        acc = 0;
        cnt = 0;
        err = 1'b0;
        for (int i = 0; i < q_data.size(); i++) begin
            d = q_data[i];
            v = fp_ref(d);
            if (q_flag[i] || d[14:10] == 5'h1f) err = 1'b1;
            s = acc + v;
`ifdef MAC_ACC_SAT_EN
            if (s > mx) begin s = mx; err = 1'b1; end
            else if (s < mn) begin s = mn; err = 1'b1; end
`else
            if (s > mx) s = s - (longint'(1) <<< accw);
            else if (s < mn) s = s + (longint'(1) <<< accw);
`endif
            acc = s;
            cnt = (cnt < 255) ? cnt + 1 : 255;
        end
    endtask

    task automatic send(input logic [15:0] d, input bit ovf, input bit unf, input bit last);
        bus.in_valid = 1'b1;
        bus.in_data  = d;
        bus.in_ovf   = ovf;
        bus.in_unf   = unf;
        bus.in_last  = last;
        for (int t = 0; t < 20; t++) begin
            if (bus.in_ready === 1'b1) break;
            @(posedge clk); #1;
        end
        chk("send_ready", 64'(bus.in_ready), 64'(1));
        @(posedge clk); #1;
        bus.in_valid = 1'b0;
        bus.in_last  = 1'b0;
        bus.in_ovf   = 1'b0;
        bus.in_unf   = 1'b0;
        q_data.push_back(d);
        q_flag.push_back(ovf | unf);
    endtask

    // Called right after the last-element handshake edge.
    task automatic get_result(input int hold);
        longint           e_acc;
        int               e_cnt;
        bit               e_err;
        logic [ACC_W-1:0] ea;
        model(ACC_W, e_acc, e_cnt, e_err);
        ea = e_acc[ACC_W-1:0];
        chk("flush_valid", 64'(bus.out_valid), 64'(0));
        chk("flush_in_ready", 64'(bus.in_ready), 64'(0));
        @(posedge clk); #1;
        chk("out_valid", 64'(bus.out_valid), 64'(1));
        chk("out_acc", 64'(bus.out_acc), 64'(ea));
        chk("out_count", 64'(bus.out_count), 64'(e_cnt));
        chk("out_err", 64'(bus.out_err), 64'(e_err));
        for (int h = 0; h < hold; h++) begin
            @(posedge clk); #1;
            chk("hold_valid", 64'(bus.out_valid), 64'(1));
            chk("hold_in_ready", 64'(bus.in_ready), 64'(0));
            chk("hold_acc", 64'(bus.out_acc), 64'(ea));
            chk("hold_count", 64'(bus.out_count), 64'(e_cnt));
            chk("hold_err", 64'(bus.out_err), 64'(e_err));
        end
        bus.out_ready = 1'b1;
        @(posedge clk); #1;
        bus.out_ready = 1'b0;
        chk("post_valid", 64'(bus.out_valid), 64'(0));
        chk("post_in_ready", 64'(bus.in_ready), 64'(1));
        chk("post_acc_kept", 64'(bus.out_acc), 64'(ea));
        q_data.delete();
        q_flag.delete();
    endtask

    initial begin
        longint e_acc_s;
        int     e_cnt_s;
        bit     e_err_s;
        int     n;

        bus.in_valid = 0; bus.in_data = '0; bus.in_ovf = 0; bus.in_unf = 0;
        bus.in_last = 0;  bus.out_ready = 0;
        bus_s.in_valid = 0; bus_s.in_data = '0; bus_s.in_ovf = 0; bus_s.in_unf = 0;
        bus_s.in_last = 0;  bus_s.out_ready = 0;

        // Reset state
        repeat (3) @(posedge clk);
        #1;
        chk("rst_in_ready", 64'(bus.in_ready), 64'(0));
        chk("rst_out_valid", 64'(bus.out_valid), 64'(0));
        chk("rst_out_acc", 64'(bus.out_acc), 64'(0));
        chk("rst_out_count", 64'(bus.out_count), 64'(0));
        chk("rst_out_err", 64'(bus.out_err), 64'(0));
        rst = 1'b0;
        @(posedge clk); #1;
        chk("idle_in_ready", 64'(bus.in_ready), 64'(1));

        // Single 1.0
        send(16'h3C00, 0, 0, 1);
        get_result(0);
        chk("t1_acc", 64'(bus.out_acc), 64'h0000_0100_0000);
        chk("t1_count", 64'(bus.out_count), 64'(1));

        // 1.0 - 2.5 + 0.5 = -1.0
        send(16'h3C00, 0, 0, 0);
        send(16'hC100, 0, 0, 0);
        send(16'h3800, 0, 0, 1);
        get_result(0);
        chk("t2_acc", 64'(bus.out_acc), 64'h0000_FFFF_FF00_0000);
        chk("t2_count", 64'(bus.out_count), 64'(3));

        // Backpressure then fresh vector
        send(16'h3C00, 0, 0, 1);
        get_result(5);
        send(16'h4000, 0, 0, 1);
        get_result(0);
        chk("t3_acc", 64'(bus.out_acc), 64'h0000_0200_0000);

        // Error flags
        send(16'h3C00, 1, 0, 1);
        get_result(1);
        chk("t4_ovf_err", 64'(bus.out_err), 64'(1));
        chk("t4_ovf_acc", 64'(bus.out_acc), 64'h0000_0100_0000);
        send(16'h3C00, 0, 1, 0);
        send(16'h3C00, 0, 0, 1);
        get_result(0);
        send(16'h3C00, 0, 0, 1);
        get_result(0);
        chk("t4_clean_err", 64'(bus.out_err), 64'(0));
        send(16'h7C00, 0, 0, 1);
        get_result(0);
        chk("t4_inf_acc", 64'(bus.out_acc), 64'(0));
        chk("t4_inf_err", 64'(bus.out_err), 64'(1));

        // Overflow on the 41-bit instance
        bus_s.in_valid = 1'b1;
        bus_s.in_data  = 16'h7BFF;
        bus_s.in_last  = 1'b0;
        chk("t5_ready0", 64'(bus_s.in_ready), 64'(1));
        @(posedge clk); #1;
        bus_s.in_last = 1'b1;
        chk("t5_ready1", 64'(bus_s.in_ready), 64'(1));
        @(posedge clk); #1;
        bus_s.in_valid = 1'b0;
        bus_s.in_last  = 1'b0;
        @(posedge clk); #1;
        q_data.push_back(16'h7BFF); q_flag.push_back(1'b0);
        q_data.push_back(16'h7BFF); q_flag.push_back(1'b0);
        model(ACC_W_S, e_acc_s, e_cnt_s, e_err_s);
        q_data.delete();
        q_flag.delete();
        chk("t5_valid", 64'(bus_s.out_valid), 64'(1));
        chk("t5_acc_model", 64'(bus_s.out_acc), 64'(e_acc_s[ACC_W_S-1:0]));
        chk("t5_err_model", 64'(bus_s.out_err), 64'(e_err_s));
        chk("t5_count", 64'(bus_s.out_count), 64'(2));
`ifdef MAC_ACC_SAT_EN
        chk("t5_acc", 64'(bus_s.out_acc), 64'h0FF_FFFF_FFFF);
        chk("t5_err", 64'(bus_s.out_err), 64'(1));
`else
        chk("t5_acc", 64'(bus_s.out_acc), 64'h1FF_C000_0000);
        chk("t5_err", 64'(bus_s.out_err), 64'(0));
`endif
        bus_s.out_ready = 1'b1;
        @(posedge clk); #1;
        bus_s.out_ready = 1'b0;
        chk("t5_released", 64'(bus_s.out_valid), 64'(0));

        // Mid-vector reset
        send(16'h3C00, 0, 0, 0);
        send(16'h3C00, 0, 0, 0);
        q_data.delete();
        q_flag.delete();
        rst = 1'b1;
        @(posedge clk); #1;
        chk("t6_rst_in_ready", 64'(bus.in_ready), 64'(0));
        chk("t6_rst_valid", 64'(bus.out_valid), 64'(0));
        rst = 1'b0;
        for (int k = 0; k < 3; k++) begin
            @(posedge clk); #1;
            chk("t6_no_valid", 64'(bus.out_valid), 64'(0));
        end
        send(16'h3C00, 0, 0, 1);
        get_result(0);
        chk("t6_acc", 64'(bus.out_acc), 64'h0000_0100_0000);
        chk("t6_count", 64'(bus.out_count), 64'(1));

        // Count saturation
        for (int k = 0; k < 260; k++) send(16'h0000, 0, 0, k == 259);
        get_result(0);
        chk("cnt_sat", 64'(bus.out_count), 64'(255));

        // Random vectors against the model
        for (int v = 0; v < 25; v++) begin
            n = $urandom_range(1, 8);
            for (int k = 0; k < n; k++) begin
                send(16'($urandom), $urandom_range(0, 7) == 0, $urandom_range(0, 7) == 0, k == n - 1);
                if (k < n - 1) begin
                    for (int g = $urandom_range(0, 2); g > 0; g--) begin
                        @(posedge clk); #1;
                    end
                end
            end
            get_result($urandom_range(0, 3));
        end

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
        $finish;
    end

endmodule
